// File: rtl/toggle_checker.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_checker
//  Description : Samples asynchronous toggling input `a`, measures edge-to-edge
//                intervals, locks on the expected half-period and raises a
//                sticky error on a bad interval or a stuck input.
//                Define TOGGLE_CHECKER_GLITCH_FILT_EN to enable a 2-cycle
//                stability filter that suppresses single-cycle glitches.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_checker #(
    parameter int EXP_HALF = 10,
    parameter int TOL      = 1,
    parameter int LOCK_N   = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             clr,
    output logic             x,
    output logic             y,
    output logic             locked,
    output logic [CNT_W-1:0] interval
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam int               c_GW   = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] c_LO   = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] c_HI   = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] c_TMO  = CNT_W'(EXP_HALF + TOL - 1);
    localparam logic [c_GW-1:0]  c_LOCK = c_GW'(LOCK_N);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_edge;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_meas;
    logic             w_good;
    logic [c_GW-1:0]  r_good_cnt;
    logic [c_GW-1:0]  w_good_inc;
    state_t           r_state;

`ifdef TOGGLE_CHECKER_GLITCH_FILT_EN
    logic r_sync3;

    // r_prev tracks the last accepted level; it moves only once sync2 has been stable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= a;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_edge) begin
                r_prev <= r_sync3;
            end
        end
    end

    assign w_edge = (r_sync2 == r_sync3) && (r_sync3 != r_prev);
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= a;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 ^ r_prev;
`endif

    assign w_meas     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_good     = (w_meas >= c_LO) && (w_meas <= c_HI);
    assign w_good_inc = r_good_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_good_cnt <= '0;
            r_state    <= S_IDLE;
            x          <= 1'b0;
            y          <= 1'b0;
            locked     <= 1'b0;
            interval   <= '0;
        end else begin
            // Edge pulse and interval capture are independent of clr
            x <= w_edge;
            if (w_edge) begin
                interval <= w_meas;
            end

            if (clr) begin
                r_state    <= S_IDLE;
                r_good_cnt <= '0;
                r_cnt      <= '0;
                y          <= 1'b0;
                locked     <= 1'b0;
            end else begin
                if (w_edge) begin
                    r_cnt <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_state    <= S_MEASURE;
                            r_good_cnt <= '0;
                        end
                    end
                    S_MEASURE: begin
                        if (w_edge) begin
                            if (!w_good) begin
                                r_good_cnt <= '0;
                            end else if (w_good_inc == c_LOCK) begin
                                r_state    <= S_LOCKED;
                                r_good_cnt <= '0;
                                locked     <= 1'b1;
                            end else begin
                                r_good_cnt <= w_good_inc;
                            end
                        end
                    end
                    S_LOCKED: begin
                        // Timeout fires as cnt steps onto EXP_HALF+TOL without an edge
                        if ((w_edge && !w_good) || (!w_edge && (r_cnt == c_TMO))) begin
                            r_state <= S_ERROR;
                            y       <= 1'b1;
                            locked  <= 1'b0;
                        end
                    end
                    S_ERROR: begin
                        r_state <= S_ERROR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toggle_checker.sv
`default_nettype none
// Bench for toggle_checker: directed and random segments of `a`, checked every
// cycle against an edge-time model derived from the behavioural rules.
module tb_toggle_checker;

    localparam int EXP_HALF = 10;
    localparam int TOL      = 1;
    localparam int LOCK_N   = 2;
    localparam int CNT_W    = 8;
    localparam int MAXN     = 1000;
`ifdef TOGGLE_CHECKER_GLITCH_FILT_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             a;
    logic             clr;
    logic             x;
    logic             y;
    logic             locked;
    logic [CNT_W-1:0] interval;

    toggle_checker #(
        .EXP_HALF (EXP_HALF),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .clr      (clr),
        .x        (x),
        .y        (y),
        .locked   (locked),
        .interval (interval)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    logic a_arr   [0:MAXN-1];
    logic clr_arr [0:MAXN-1];
    logic e_arr   [0:MAXN+7];
    int   wp;
    logic cur;
    logic clr_pend;

    // Model state: mode 0=idle 1=measure 2=locked 3=error; m_last = posedge of last edge/clr
    int m_mode, m_last, m_streak;
    int exp_x, exp_iv;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp_v);
        n_checks++;
        assert (got === exp_v)
        else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp_v);
        end
    endtask

    task automatic seg_begin();
        wp       = 0;
        cur      = 1'b0;
        clr_pend = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < MAXN) begin
                a_arr[wp]   = cur;
                clr_arr[wp] = clr_pend;
                clr_pend    = 1'b0;
                wp++;
            end
        end
    endtask

    task automatic tog(input int n);
        cur = ~cur;
        hold(n);
    endtask

    // Step k drives a before posedge k; an accepted change is seen on x 2 posedges later.
    task automatic compute_edges();
        logic lvl, acc;
        lvl = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < MAXN + 8; i++) e_arr[i] = 1'b0;
        for (int k = 0; k < wp; k++) begin
            if (FILT) begin
                if (a_arr[k] == lvl && a_arr[k] != acc) begin
                    acc          = a_arr[k];
                    e_arr[k + 2] = 1'b1;
                end
            end else if (a_arr[k] != lvl) begin
                e_arr[k + 2] = 1'b1;
            end
            lvl = a_arr[k];
        end
    endtask

    task automatic model_step(input int p);
        int gap, meas;
        bit ed, gd;
        ed  = e_arr[p];
        gap = p - m_last;
        gd  = 1'b0;
        exp_x = ed ? 1 : 0;
        if (ed) begin
            meas   = (gap > 255) ? 255 : gap;
            exp_iv = meas;
            gd     = (meas >= EXP_HALF - TOL) && (meas <= EXP_HALF + TOL);
        end
        if (clr_arr[p]) begin
            m_mode   = 0;
            m_streak = 0;
            m_last   = p;
        end else begin
            if (ed) m_last = p;
            case (m_mode)
                0: if (ed) begin m_mode = 1; m_streak = 0; end
                1: if (ed) begin
                       if (gd) begin
                           m_streak++;
                           if (m_streak >= LOCK_N) m_mode = 2;
                       end else begin
                           m_streak = 0;
                       end
                   end
                2: if ((ed && !gd) || (!ed && gap == EXP_HALF + TOL)) m_mode = 3;
                default: ;
            endcase
        end
    endtask

    // Asserts reset mid-cycle, checks async clearing, releases, then plays the segment.
    task automatic run_seg(input string tag);
        reset = 1'b0;
        a     = 1'b0;
        clr   = 1'b0;
        #1;
        chk({tag, "_rst_x"},  8'(x),      8'd0);
        chk({tag, "_rst_y"},  8'(y),      8'd0);
        chk({tag, "_rst_lk"}, 8'(locked), 8'd0);
        chk({tag, "_rst_iv"}, interval,   8'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        compute_edges();
        m_mode   = 0;
        m_last   = -1;
        m_streak = 0;
        exp_iv   = 0;
        for (int p = 0; p < wp; p++) begin
            a   = a_arr[p];
            clr = clr_arr[p];
            @(posedge clk);
            cyc++;
            model_step(p);
            #1;
            chk({tag, "_x"},  8'(x),      8'(exp_x));
            chk({tag, "_y"},  8'(y),      (m_mode == 3) ? 8'd1 : 8'd0);
            chk({tag, "_lk"}, 8'(locked), (m_mode == 2) ? 8'd1 : 8'd0);
            chk({tag, "_iv"}, interval,   8'(exp_iv));
        end
        clr = 1'b0;
    endtask

    initial begin
        int r, h, g;
        reset = 1'b1;
        a     = 1'b0;
        clr   = 1'b0;
        #2;

        // Lock, one short half-period, clr, relock, then stuck input
        seg_begin();
        hold(3);
        repeat (8) tog(10);
        tog(8);
        repeat (3) tog(10);
        clr_pend = 1'b1;
        repeat (6) tog(10);
        hold(30);
        run_seg("seqA");

        // End while locked so the next reset lands in LOCKED
        seg_begin();
        hold(5);
        repeat (6) tog(10);
        hold(3);
        run_seg("seqB");

        // Single-cycle glitch in the middle of a half-period
        seg_begin();
        hold(4);
        repeat (5) tog(10);
        tog(5);
        tog(1);
        tog(4);
        repeat (4) tog(10);
        hold(5);
        run_seg("seqC");

        // Long idle (saturated first interval) then randomized traffic
        seg_begin();
        hold(270);
        while (wp < 900) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) clr_pend = 1'b1;
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 14))
                                            : int'($urandom_range(9, 11));
            if (r == 1) h = int'($urandom_range(12, 20));
            if (r >= 2 && r <= 4 && h >= 5) begin
                g = int'($urandom_range(2, h - 3));
                tog(g);
                tog(1);
                tog(h - g - 1);
            end else begin
                tog(h);
            end
        end
        run_seg("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toggle_checker.md
Name: toggle_checker

Overview:
- Receive-side companion to the chip's square-wave stimulus: samples the asynchronous toggling input `a`, detects each edge and measures the cycle interval between edges.
- Locks once intervals match an expected half-period; flags sticky errors on a bad interval or a stuck input.
- Sits directly behind the chip input pad, in place of ad-hoc pass-through logic in the pipecleaner top, and drives the `x`/`y` observation outputs.

Parameters:
- EXP_HALF, 10, expected clk cycles between consecutive edges of `a`.
- TOL, 1, allowed ± deviation in cycles; accepted window is [EXP_HALF-TOL, EXP_HALF+TOL].
- LOCK_N, 2, consecutive good intervals required to enter LOCKED.
- CNT_W, 8, interval counter width; must satisfy 2^CNT_W-1 > EXP_HALF+TOL.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- a  in  1  asynchronous toggling input.
- clr  in  1  synchronous error/lock clear, active-high, one cycle.
- x  out  1  registered one-cycle pulse per accepted edge of `a`.
- y  out  1  sticky error flag.
- locked  out  1  high while FSM in LOCKED.
- interval  out  CNT_W  last measured edge-to-edge interval, in cycles.

Behaviour:
- Reset (reset=0, async): sync flops=0, prev=0, cnt=0, good_cnt=0, state=IDLE, x=0, y=0, locked=0, interval=0.
- Synchronizer: 2 flops, then `prev` flop; edge = sync2 ^ prev.
- Latency: `x` is high for exactly one cycle, registered; it rises on the 3rd posedge after the first posedge that samples the new level of `a`.
- Counter:
  - cnt clears to 0 on an edge cycle and increments otherwise.
  - cnt saturates at all-ones and never wraps.
  - On an edge, the measured value = cnt+1 and is loaded into `interval`. Example: edges 10 cycles apart give interval=10.
- good = measured value within [EXP_HALF-TOL, EXP_HALF+TOL].
- FSM:
  - IDLE: first edge → MEASURE. That first interval is not judged, since no reference edge exists; `interval` is still loaded.
  - MEASURE: on edge, good → good_cnt+1, reaching LOCK_N → LOCKED. Bad interval → good_cnt=0, stays MEASURE, y unchanged.
  - LOCKED: edge with bad interval → ERROR.
  - LOCKED timeout: cnt reaching EXP_HALF+TOL with no edge → ERROR. This is the stuck-input case; a good edge is allowed to arrive on cnt=EXP_HALF+TOL-1.
  - ERROR: y=1, locked=0. Edges still pulse `x` and update `interval`. Exits only via clr or reset.
  - MEASURE and IDLE never time out.
- clr: state → IDLE, y=0, good_cnt=0, cnt=0, locked=0. `interval` is held.
- clr coincident with an edge: clr wins for state, flags and cnt. `x` still pulses and `interval` still loads.
- y is set in the cycle after the offending edge or timeout is registered, and is held until clr/reset.
- locked = (state==LOCKED), registered.
- Reset mid-operation: all state returns to reset values immediately. After release the first edge again goes IDLE → MEASURE.

Optional Feature:
- Macro: TOGGLE_CHECKER_GLITCH_FILT_EN.
- Defined: a 2-cycle stability filter follows the synchronizer. A level change is accepted only when sync2 holds the new value for 2 consecutive cycles; 1-cycle glitches are ignored entirely (no x, no interval update). Adds 1 cycle to `x` latency (4th posedge).
- Undefined: no filter. Every sync2 change is an edge, so a 1-cycle glitch produces two edges.

Test Plan:
- 10 ns clk, reset low for 10 ns, a toggles every 100 ns → x pulses every 10 cycles, interval=10, locked=1 after the 3rd edge, y=0 through 1000 ns.
- Locked, then one half-period shortened to 80 ns → interval=8, y=1 and locked=0 the cycle after that edge; y stays 1 on later good edges.
- Locked, then a held constant → y=1 exactly 11 cycles after the last edge (cnt reaches 11); x stays 0.
- In ERROR, pulse clr for one cycle, then normal toggling → y=0 immediately; locked=1 again after LOCK_N+1 edges.
- Reset asserted for 1 cycle while LOCKED → x, y, locked and interval are 0 asynchronously, before the next clk edge; relock follows the same sequence as from power-up.
- Inject a 1-cycle glitch on a mid-half-period → without macro: two x pulses and y=1 if locked; with TOGGLE_CHECKER_GLITCH_FILT_EN: no x pulse, interval unchanged, locked stays 1.
